// File: rtl/dda_frame_tx.sv
// ---------------------------------------------------------------------------
// dda_frame_tx
//   Takes a snapshot of the Lorenz DDA solver state (x/y/z) when the solver
//   strobes a new step. Each accepted step is sent to a byte-wide UART
//   transmitter as one framed packet:
//       SYNC, x bytes, y bytes, z bytes (each MSB first), XOR checksum
//   A decimation counter picks one step out of every DECIM. A step that is
//   picked while a frame is still in flight is dropped and counted in a
//   saturating drop counter. Each byte uses a full handshake with the UART:
//   pulse transmit, wait for the busy flag to rise, then wait for it to fall.
//
// Parameters
//   N      state word width, a multiple of 8
//   DECIM  one frame per DECIM accepted state_valid pulses (1..255)
//   SYNC   frame start byte
//
// Ports
//   clk                   system clock
//   rst_n                 asynchronous active-low reset
//   enable                1 = stream frames, 0 = ignore state_valid
//   state_valid           1-cycle strobe: x/y/z hold a new solver step
//   x, y, z               solver state words
//   uart_transmit         1-cycle pulse: UART sends uart_tx_byte
//   uart_tx_byte          byte to send, held from the pulse until the byte is done
//   uart_is_transmitting  UART busy flag
//   busy                  high while a frame is in flight
//   frame_done            1-cycle pulse after the final byte completes
//   drop_count            frames skipped because busy, saturates at 255
// ---------------------------------------------------------------------------
module dda_frame_tx #(
    parameter int          N     = 16,
    parameter int          DECIM = 1,
    parameter logic [7:0]  SYNC  = 8'hA5
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         enable,
    input  logic         state_valid,
    input  logic [N-1:0] x,
    input  logic [N-1:0] y,
    input  logic [N-1:0] z,
    output logic         uart_transmit,
    output logic [7:0]   uart_tx_byte,
    input  logic         uart_is_transmitting,
    output logic         busy,
    output logic         frame_done,
    output logic [7:0]   drop_count
);

    localparam int BPV   = N / 8;
    localparam int NDATA = 3 * BPV;
    localparam int L     = 2 + NDATA;
    localparam int IW    = $clog2(L + 1);

    localparam logic [IW-1:0] LAST_IDX   = IW'(L - 1);
    localparam logic [7:0]    DECIM_LAST = 8'(DECIM - 1);

    typedef enum logic [2:0] {
        IDLE,
        SEND,
        WAIT_BUSY,
        WAIT_DONE,
        DONE
    } state_t;

    state_t           state;
    logic [7:0]       decim_cnt;
    logic [3*N-1:0]   snap;
    logic [7:0]       chk;
    logic [IW-1:0]    idx;

    logic             selected;
    logic [7:0]       in_chk;
    logic [7:0]       next_byte;

    // XOR of all data bytes of a packed {x, y, z} word.
    function automatic logic [7:0] xor_bytes(input logic [3*N-1:0] d);
        logic [3*N-1:0] t;
        logic [7:0]     c;
        t = d;
        c = '0;
        for (int k = 0; k < NDATA; k++) begin
            c = c ^ t[7:0];
            t = t >> 8;
        end
        return c;
    endfunction

    // Byte at frame position i: SYNC first, CHK last, data bytes taken
    // MSB first from the snapshot in between.
    function automatic logic [7:0] byte_at(input logic [IW-1:0]  i,
                                           input logic [3*N-1:0] s,
                                           input logic [7:0]     chk_in);
        logic [3*N-1:0] sh;
        int unsigned    shamt;
        if (i == '0) begin
            return SYNC;
        end else if (i == LAST_IDX) begin
            return chk_in;
        end else begin
            shamt = 32'(8 * (int'(i) - 1));
            sh    = s << shamt;
            return sh[3*N-1 -: 8];
        end
    endfunction

    assign selected  = enable && state_valid && (decim_cnt == DECIM_LAST);
    assign in_chk    = xor_bytes({x, y, z});
    assign next_byte = byte_at(idx + IW'(1), snap, chk);

    // Decimation counter. It only advances on strobes while enabled and is
    // forced to zero while disabled, so re-enabling starts a fresh count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            decim_cnt <= '0;
        end else if (!enable) begin
            decim_cnt <= '0;
        end else if (state_valid) begin
            decim_cnt <= selected ? 8'd0 : decim_cnt + 8'd1;
        end
    end

    // Drop accounting. A selected strobe is dropped whenever the FSM is not
    // idle, which includes the DONE cycle in which frame_done is high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_count <= '0;
        end else if (selected && (state != IDLE) && (drop_count != 8'hFF)) begin
            drop_count <= drop_count + 8'd1;
        end
    end

    // Frame FSM with registered outputs. The snapshot and its checksum are
    // captured together on the accepting edge, so later strobes cannot
    // disturb a frame in flight. The transmit pulse is raised on the same
    // edge that enters SEND, so the pulse lines up with the SEND cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            snap          <= '0;
            chk           <= '0;
            idx           <= '0;
            uart_transmit <= 1'b0;
            uart_tx_byte  <= '0;
            busy          <= 1'b0;
            frame_done    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (selected) begin
                        snap          <= {x, y, z};
                        chk           <= in_chk;
                        idx           <= '0;
                        uart_transmit <= 1'b1;
                        uart_tx_byte  <= SYNC;
                        busy          <= 1'b1;
                        state         <= SEND;
                    end
                end
                SEND: begin
                    uart_transmit <= 1'b0;
                    state         <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    if (uart_is_transmitting) begin
                        state <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    if (!uart_is_transmitting) begin
                        if (idx == LAST_IDX) begin
                            frame_done <= 1'b1;
                            state      <= DONE;
                        end else begin
                            idx           <= idx + IW'(1);
                            uart_transmit <= 1'b1;
                            uart_tx_byte  <= next_byte;
                            state         <= SEND;
                        end
                    end
                end
                DONE: begin
                    frame_done <= 1'b0;
                    busy       <= 1'b0;
                    idx        <= '0;
                    state      <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dda_frame_tx.sv
// ---------------------------------------------------------------------------
// tb_dda_frame_tx
//   Self-checking bench for dda_frame_tx. Two instances share clock and
//   reset: dut1 with DECIM=1 and dut4 with DECIM=4. Each one drives a small
//   behavioural UART that records every transmitted byte, raises its busy
//   flag after a programmable delay and holds it for a programmable byte time.
//   Expected frames are built directly from the packet format: SYNC, the
//   state bytes MSB first, then the XOR of the data bytes.
// ---------------------------------------------------------------------------
module tb_dda_frame_tx;

    localparam int         N    = 16;
    localparam logic [7:0] SYNC = 8'hA5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic enable = 1'b1;

    logic          valid1 = 1'b0, valid4 = 1'b0;
    logic [N-1:0]  x1 = '0, y1 = '0, z1 = '0;
    logic [N-1:0]  x4 = '0, y4 = '0, z4 = '0;
    logic          tx1, tx4, busy1, busy4, fd1, fd4;
    logic [7:0]    byte1, byte4, drop1, drop4;
    logic          uart_busy1, uart_busy4;

    int checks = 0;
    int errors = 0;

    logic [7:0] cap1[$];
    logic [7:0] cap4[$];
    logic [7:0] exp_q[$];

    int done1 = 0, done4 = 0;
    int viol1 = 0, viol4 = 0;
    int bt1 = 2, rise1 = 0;
    int cnt1 = 0, cnt4 = 0;
    logic pend1 = 1'b0, pend4 = 1'b0;

    always #5 clk = ~clk;

    dda_frame_tx #(.N(N), .DECIM(1), .SYNC(SYNC)) dut1 (
        .clk                  (clk),
        .rst_n                (rst_n),
        .enable               (enable),
        .state_valid          (valid1),
        .x                    (x1),
        .y                    (y1),
        .z                    (z1),
        .uart_transmit        (tx1),
        .uart_tx_byte         (byte1),
        .uart_is_transmitting (uart_busy1),
        .busy                 (busy1),
        .frame_done           (fd1),
        .drop_count           (drop1)
    );

    dda_frame_tx #(.N(N), .DECIM(4), .SYNC(SYNC)) dut4 (
        .clk                  (clk),
        .rst_n                (rst_n),
        .enable               (enable),
        .state_valid          (valid4),
        .x                    (x4),
        .y                    (y4),
        .z                    (z4),
        .uart_transmit        (tx4),
        .uart_tx_byte         (byte4),
        .uart_is_transmitting (uart_busy4),
        .busy                 (busy4),
        .frame_done           (fd4),
        .drop_count           (drop4)
    );

    // UART model for dut1: records bytes, flags a transmit pulse that
    // arrives while the UART is already busy.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            uart_busy1 <= 1'b0;
            pend1      <= 1'b0;
            cnt1       <= 0;
        end else if (tx1) begin
            if (uart_busy1) viol1 <= viol1 + 1;
            cap1.push_back(byte1);
            pend1 <= 1'b1;
            cnt1  <= rise1;
        end else if (pend1) begin
            if (cnt1 == 0) begin
                uart_busy1 <= 1'b1;
                pend1      <= 1'b0;
                cnt1       <= bt1;
            end else begin
                cnt1 <= cnt1 - 1;
            end
        end else if (uart_busy1) begin
            if (cnt1 == 0) uart_busy1 <= 1'b0;
            else           cnt1 <= cnt1 - 1;
        end
    end

    // UART model for dut4 with fixed timing.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            uart_busy4 <= 1'b0;
            pend4      <= 1'b0;
            cnt4       <= 0;
        end else if (tx4) begin
            if (uart_busy4) viol4 <= viol4 + 1;
            cap4.push_back(byte4);
            pend4 <= 1'b1;
            cnt4  <= 0;
        end else if (pend4) begin
            uart_busy4 <= 1'b1;
            pend4      <= 1'b0;
            cnt4       <= 2;
        end else if (uart_busy4) begin
            if (cnt4 == 0) uart_busy4 <= 1'b0;
            else           cnt4 <= cnt4 - 1;
        end
    end

    // Count frame_done pulses per instance.
    always @(posedge clk) begin
        if (fd1) done1 <= done1 + 1;
        if (fd4) done4 <= done4 + 1;
    end

    // Single comparison point for the whole bench.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    // One state_valid pulse on the chosen instance; returns on the falling
    // edge right after the edge that sampled the pulse.
    task automatic applyStimulus(input int which, input logic [N-1:0] xv,
                                 input logic [N-1:0] yv, input logic [N-1:0] zv);
        @(negedge clk);
        if (which == 1) begin
            x1 = xv; y1 = yv; z1 = zv; valid1 = 1'b1;
        end else begin
            x4 = xv; y4 = yv; z4 = zv; valid4 = 1'b1;
        end
        @(negedge clk);
        valid1 = 1'b0;
        valid4 = 1'b0;
    endtask

    // Append the expected packet for one solver step to exp_q.
    task automatic buildFrame(input logic [N-1:0] xv, input logic [N-1:0] yv,
                              input logic [N-1:0] zv);
        logic [7:0] c;
        logic [7:0] data[6];
        data = '{xv[15:8], xv[7:0], yv[15:8], yv[7:0], zv[15:8], zv[7:0]};
        c = 8'h00;
        exp_q.push_back(SYNC);
        foreach (data[i]) begin
            exp_q.push_back(data[i]);
            c = c ^ data[i];
        end
        exp_q.push_back(c);
    endtask

    task automatic checkFrame(input string tag, input int which);
        int n;
        n = (which == 1) ? cap1.size() : cap4.size();
        checkOutput({tag, "_len"}, n, exp_q.size());
        for (int i = 0; i < n && i < exp_q.size(); i++) begin
            checkOutput($sformatf("%s_b%0d", tag, i),
                        (which == 1) ? cap1[i] : cap4[i], exp_q[i]);
        end
    endtask

    // Wait for the next frame_done of dut1, bounded by a cycle budget.
    task automatic waitDone1(input string tag, input int budget);
        int start;
        int c;
        start = done1;
        c = 0;
        while (done1 == start && c < budget) begin
            @(negedge clk);
            c++;
        end
        checkOutput({tag, "_timeout"}, (done1 == start) ? 1 : 0, 0);
        checkOutput({tag, "_idle"}, busy1, 0);
    endtask

    task automatic doReset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        cap1.delete();
        cap4.delete();
    endtask

    initial begin : main
        logic [N-1:0] rx, ry, rz;
        int drops_exp;
        int c;

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("rst_transmit", tx1, 0);
        checkOutput("rst_byte", byte1, 0);
        checkOutput("rst_busy", busy1, 0);
        checkOutput("rst_done", fd1, 0);
        checkOutput("rst_drop", drop1, 0);
        rst_n = 1'b1;

        // T1: known vector, transmit pulse the cycle after the accepting edge.
        applyStimulus(1, 16'hC000, 16'h14CD, 16'h7240);
        checkOutput("t1_latency_tx", tx1, 1);
        checkOutput("t1_latency_byte", byte1, 8'hA5);
        checkOutput("t1_busy", busy1, 1);
        waitDone1("t1", 500);
        exp_q = '{8'hA5, 8'hC0, 8'h00, 8'h14, 8'hCD, 8'h72, 8'h40, 8'h2B};
        checkFrame("t1", 1);
        checkOutput("t1_done_count", done1, 1);

        // T2: DECIM=4, frames come from the 4th and 8th pulses only.
        exp_q.delete();
        for (int p = 0; p < 8; p++) begin
            rx = N'($urandom); ry = N'($urandom); rz = N'($urandom);
            applyStimulus(4, rx, ry, rz);
            if (p % 4 == 3) buildFrame(rx, ry, rz);
            repeat (90) @(negedge clk);
        end
        checkFrame("t2", 4);
        checkOutput("t2_frames", done4, 2);
        checkOutput("t2_drop", drop4, 0);

        // T3: second pulse mid-frame is dropped, frame keeps the old data.
        cap1.delete(); exp_q.delete();
        applyStimulus(1, 16'h1234, 16'h5678, 16'h9ABC);
        repeat (5) @(negedge clk);
        applyStimulus(1, 16'hFFFF, 16'h5678, 16'h9ABC);
        waitDone1("t3a", 500);
        buildFrame(16'h1234, 16'h5678, 16'h9ABC);
        checkFrame("t3a", 1);
        checkOutput("t3_drop", drop1, 1);
        cap1.delete(); exp_q.delete();
        applyStimulus(1, 16'hFFFF, 16'h5678, 16'h9ABC);
        waitDone1("t3b", 500);
        buildFrame(16'hFFFF, 16'h5678, 16'h9ABC);
        checkFrame("t3b", 1);

        // T4: UART raises its busy flag 3 cycles late.
        rise1 = 3;
        cap1.delete(); exp_q.delete();
        applyStimulus(1, 16'h0F0F, 16'hA0A0, 16'h3C3C);
        waitDone1("t4", 800);
        buildFrame(16'h0F0F, 16'hA0A0, 16'h3C3C);
        checkFrame("t4", 1);
        checkOutput("t4_no_tx_while_busy", viol1, 0);
        rise1 = 0;

        // Enable low: strobes ignored. Enable dropping mid-frame: frame completes.
        cap1.delete(); exp_q.delete();
        enable = 1'b0;
        applyStimulus(1, 16'h1111, 16'h2222, 16'h3333);
        repeat (20) @(negedge clk);
        checkOutput("en0_no_bytes", cap1.size(), 0);
        checkOutput("en0_busy", busy1, 0);
        enable = 1'b1;
        applyStimulus(1, 16'h4444, 16'h5555, 16'h6666);
        repeat (3) @(negedge clk);
        enable = 1'b0;
        waitDone1("en_fall", 500);
        buildFrame(16'h4444, 16'h5555, 16'h6666);
        checkFrame("en_fall", 1);
        enable = 1'b1;

        // T5: reset after the third byte abandons the frame immediately.
        cap1.delete(); exp_q.delete();
        applyStimulus(1, 16'hDEAD, 16'hBEEF, 16'hCAFE);
        c = 0;
        while (cap1.size() < 3 && c < 200) begin
            @(negedge clk);
            c++;
        end
        checkOutput("t5_reach_byte3", cap1.size(), 3);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("t5_rst_tx", tx1, 0);
        checkOutput("t5_rst_byte", byte1, 0);
        checkOutput("t5_rst_busy", busy1, 0);
        checkOutput("t5_rst_drop", drop1, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        checkOutput("t5_no_more_bytes", cap1.size(), 3);
        cap1.delete();
        applyStimulus(1, 16'h0102, 16'h0304, 16'h0506);
        waitDone1("t5", 500);
        buildFrame(16'h0102, 16'h0304, 16'h0506);
        checkFrame("t5", 1);

        // T6: 300 strobes against a slow UART saturate the drop counter.
        doReset();
        bt1 = 60;
        exp_q.delete();
        @(negedge clk);
        x1 = 16'h7777; y1 = 16'h8888; z1 = 16'h9999; valid1 = 1'b1;
        repeat (300) @(negedge clk);
        valid1 = 1'b0;
        checkOutput("t6_busy", busy1, 1);
        checkOutput("t6_drop_sat", drop1, (299 > 255) ? 255 : 299);
        waitDone1("t6", 2000);
        buildFrame(16'h7777, 16'h8888, 16'h9999);
        checkFrame("t6", 1);

        // Randomised frames, random UART timing, optional dropped strobe.
        doReset();
        drops_exp = 0;
        for (int it = 0; it < 20; it++) begin
            bt1   = $urandom_range(0, 3);
            rise1 = $urandom_range(0, 3);
            rx = N'($urandom); ry = N'($urandom); rz = N'($urandom);
            cap1.delete(); exp_q.delete();
            buildFrame(rx, ry, rz);
            applyStimulus(1, rx, ry, rz);
            if ($urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(0, 3)) @(negedge clk);
                applyStimulus(1, N'($urandom), N'($urandom), N'($urandom));
                drops_exp++;
            end
            waitDone1($sformatf("rnd%0d", it), 500);
            checkFrame($sformatf("rnd%0d", it), 1);
            checkOutput($sformatf("rnd%0d_drop", it), drop1,
                        (drops_exp > 255) ? 255 : drops_exp);
            repeat ($urandom_range(1, 5)) @(negedge clk);
        end
        checkOutput("no_tx_while_busy1", viol1, 0);
        checkOutput("no_tx_while_busy4", viol4, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #3000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
